// File: rtl/ram_dp_clr_if.sv
// Port bundle for ram_dp_clr: write/read/clear requests in, registered read data and status out.
interface ram_dp_clr_if #(
  parameter int AW = 3,
  parameter int DW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          clr_req;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with registered read, optional read-during-write bypass
// and a clear sequencer that fills every word with INIT_VAL after reset or on request.
//
// state   | meaning
// S_IDLE  | normal operation, write and read ports serviced
// S_CLEAR | sweeping INIT_VAL into mem[r_cnt], port requests ignored
module ram_dp_clr #(
  parameter int              AW       = 3,
  parameter int              DW       = 4,
  parameter bit              BYPASS   = 1'b1,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic        clk,
  input  logic        reset,
  ram_dp_clr_if.slave bus
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_data;
  logic          w_rd_go;
  logic          w_hit;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_mem_addr  = bus.wr_addr;
    w_mem_data  = bus.wr_data;
    w_rd_go     = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_cnt;
        w_mem_data = INIT_VAL;
        if (r_cnt == AW'(DEPTH - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      S_IDLE: begin
        // a clear request wins over any port access on the same edge
        if (bus.clr_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          w_mem_we = bus.wr_en;
          w_rd_go  = bus.rd_en;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // storage is not reset; the sweep initialises it
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  assign w_hit = BYPASS && bus.wr_en && (bus.wr_addr == bus.rd_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_go;
      if (w_rd_go) r_rd_data <= w_hit ? bus.wr_data : r_mem[bus.rd_addr];
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = (r_state == S_CLEAR);
endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
- Parametrised simple-dual-port RAM: one write port, one read port, both usable in the same cycle.
- Registered read data with a valid strobe.
- Selectable read-during-write bypass.
- Built-in clear sequencer that fills every word with INIT_VAL after reset and on request.
- Successor to the single-port rw-muxed RAM. It sits between producer/consumer logic and storage in the datapath and is exercised by the team's probador-style benches against a behavioural model.

Parameters:
- AW, 3, address width; DEPTH = 2**AW words.
- DW, 4, data width.
- BYPASS, 1, 1: a same-address read in a write cycle returns the new wr_data; 0: it returns the old contents.
- INIT_VAL, 0, DW-bit value written by the clear sequencer.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- wr_en  input  1  write strobe.
- wr_addr  input  AW  write address.
- wr_data  input  DW  write data.
- rd_en  input  1  read strobe.
- rd_addr  input  AW  read address.
- clr_req  input  1  request a full-memory clear.
- rd_data  output  DW  registered read data.
- rd_valid  output  1  rd_data updated this cycle.
- busy  output  1  clear sequence in progress; port requests are ignored.

Behaviour:
- Reset (reset=0, asynchronous):
  - rd_data=0, rd_valid=0, busy=1.
  - FSM=CLEAR, clear counter=0.
  - Array contents are not reset directly; the sweep clears them.
- FSM states: IDLE and CLEAR.
- CLEAR state:
  - Each rising edge writes INIT_VAL to mem[cnt], then cnt+1.
  - On the edge that writes cnt=DEPTH-1: FSM->IDLE, busy->0, cnt->0.
  - busy is therefore high for exactly DEPTH edges after reset release.
  - wr_en, rd_en and clr_req are ignored; rd_valid=0; rd_data holds its value.
- IDLE state:
  - clr_req=1 sampled: FSM->CLEAR, busy->1, cnt=0. Any wr_en/rd_en on that same edge is dropped (clear wins). The next DEPTH edges perform the sweep.
  - Otherwise, wr_en=1: mem[wr_addr] <= wr_data on the edge.
  - Otherwise, rd_en=1: rd_data <= mem[rd_addr] on the edge, and rd_valid=1 for the following cycle. Read latency is 1 cycle.
  - rd_en=0: rd_valid=0 and rd_data holds its last value.
- Simultaneous wr_en and rd_en, different addresses: both complete independently.
- Simultaneous wr_en and rd_en, same address: BYPASS=1 gives rd_data=wr_data; BYPASS=0 gives the pre-write contents. The array is updated in both cases.
- Address wrap: addresses are AW bits, so there is no out-of-range case. The clear counter is AW+1 bits, or terminates by compare, so it never wraps before DEPTH writes complete.
- clr_req while busy: ignored; the sweep is not restarted.
- Reset asserted mid-sweep or mid-access: immediately returns to the reset values. On release, the sweep restarts from address 0 for the full DEPTH edges.
- Width rules: no arithmetic on data; widths are DW end to end. Output is X-free after reset.

Test Plan:
- Reset release, AW=3, DW=4 -> busy=1 for exactly 8 rising edges, then 0. Reads of addresses 0..7 then return 0 with rd_valid=1 one cycle after each rd_en.
- Write 1..8 to addresses 0..7 on consecutive cycles, then read 0..7 -> rd_data sequence 1,2,...,8, each one cycle after its rd_en. rd_valid is high 8 cycles.
- BYPASS=1: mem[3]=5; wr_en addr3 data 9 with rd_en addr3 in the same cycle -> rd_data=9. Repeat with BYPASS=0 -> rd_data=5; a subsequent read gives 9.
- After the fill, pulse clr_req with wr_en addr2 data 7 in the same cycle -> write dropped, busy high 8 cycles. wr_en/rd_en during busy have no effect and rd_valid=0. Afterwards all addresses read INIT_VAL=0.
- Assert reset at sweep address 4 for 1 cycle -> rd_valid=0 and busy=1 immediately. After release, busy is high for a full 8 edges and all words read 0.
- Write to address 6 and read address 1 in the same cycle -> rd_data=mem[1] old value. Next cycle, reading address 6 returns the written data.
